// File: rtl/nmi_req_guard_pkg.sv
// Shared types and defaults for the nmi request guard (register slice + bus watchdog).
package nmi_req_guard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int          NMI_ADDR_W   = 32;
  localparam int          NMI_DATA_W   = 32;
  localparam int          NMI_STRB_W   = 4;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/nmi_req_guard_if.sv
// nmi bus: valid/ready handshake with address, write data, byte strobes and read data.
interface nmi_if;
  import nmi_req_guard_pkg::*;

  logic                  valid;
  logic [NMI_ADDR_W-1:0] addr;
  logic [NMI_DATA_W-1:0] wdata;
  logic [NMI_STRB_W-1:0] wstrb;
  logic [NMI_DATA_W-1:0] rdata;
  logic                  ready;

  modport master (output valid, addr, wdata, wstrb, input  rdata, ready);
  modport slave  (input  valid, addr, wdata, wstrb, output rdata, ready);

endinterface

// File: rtl/nmi_req_guard_cells.sv
// Standard flop cells: dffr (sync active-low reset) and dffer (same, with load enable).
module dffr #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) q <= '0;
    else          q <= d;
  end

endmodule

module dffer #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/nmi_req_guard_tmo.sv
// Timeout counter: cleared per request, counts stalled cycles, flags the last allowed cycle.
module nmi_req_guard_tmo #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  // Holds at LAST instead of wrapping; the FSM leaves REQ on that cycle anyway.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)          cnt_q <= '0;
    else if (clr)          cnt_q <= '0;
    else if (en && !hit)   cnt_q <= cnt_q + 1'b1;
  end

  // Ungated terminal count so the FSM's enable never loops back through here.
  assign hit = (cnt_q == LAST);

endmodule

// File: rtl/nmi_req_guard.sv
// Register slice + watchdog between a core's nmi master and the SoC fabric.
// Optional statistics counters built only when NMI_REQ_GUARD_STAT_EN is defined.
module nmi_req_guard
  import nmi_req_guard_pkg::*;
#(
  parameter  int          TIMEOUT_CYC = 1024,
  localparam int          CNT_W       = $clog2(TIMEOUT_CYC + 1),
  parameter  logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  nmi_if.slave         up,
  nmi_if.master        dn,
  input  logic         clr_i,
  output logic         timeout_o,
  output logic [31:0]  err_addr_o,
  output logic [31:0]  txn_cnt_o,
  output logic [15:0]  tmo_cnt_o
);

  state_e state_q, state_d;

  logic req_ld, rsp_ld, tmo_set, cnt_clr, cnt_en, tmo_hit;

  logic [NMI_ADDR_W-1:0] addr_q;
  logic [NMI_DATA_W-1:0] wdata_q;
  logic [NMI_STRB_W-1:0] wstrb_q;
  logic [NMI_DATA_W-1:0] rdata_q, rdata_d;

  logic        timeout_d;
  logic        err_ld;
  logic [31:0] err_addr_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // dn.ready wins over the terminal count when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    req_ld  = 1'b0;
    rsp_ld  = 1'b0;
    tmo_set = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (up.valid) begin
          req_ld  = 1'b1;
          cnt_clr = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dn.ready) begin
          rsp_ld  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_en = 1'b1;
          if (tmo_hit) begin
            tmo_set = 1'b1;
            rsp_ld  = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  nmi_req_guard_tmo #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_tmo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .hit     (tmo_hit)
  );

  dffer #(.W(NMI_ADDR_W)) u_addr  (.clk_i(clk_i), .rst_n_i(rst_n_i), .en(req_ld), .d(up.addr),  .q(addr_q));
  dffer #(.W(NMI_DATA_W)) u_wdata (.clk_i(clk_i), .rst_n_i(rst_n_i), .en(req_ld), .d(up.wdata), .q(wdata_q));
  dffer #(.W(NMI_STRB_W)) u_wstrb (.clk_i(clk_i), .rst_n_i(rst_n_i), .en(req_ld), .d(up.wstrb), .q(wstrb_q));

  // Writes capture dn.rdata too, so up.rdata always reflects the last response.
  assign rdata_d = dn.ready ? dn.rdata : ERR_DATA;

  dffer #(.W(NMI_DATA_W)) u_rdata (.clk_i(clk_i), .rst_n_i(rst_n_i), .en(rsp_ld), .d(rdata_d), .q(rdata_q));

  // A timeout in the same cycle as clr_i takes precedence over the clear.
  assign timeout_d  = tmo_set | (timeout_o & ~clr_i);
  assign err_ld     = tmo_set | clr_i;
  assign err_addr_d = tmo_set ? addr_q : 32'h0;

  dffr  #(.W(1))  u_tmo_flag (.clk_i(clk_i), .rst_n_i(rst_n_i), .d(timeout_d), .q(timeout_o));
  dffer #(.W(32)) u_err_addr (.clk_i(clk_i), .rst_n_i(rst_n_i), .en(err_ld), .d(err_addr_d), .q(err_addr_o));

  assign dn.valid = (state_q == REQ);
  assign dn.addr  = addr_q;
  assign dn.wdata = wdata_q;
  assign dn.wstrb = wstrb_q;

  assign up.ready = (state_q == RESP);
  assign up.rdata = rdata_q;

`ifdef NMI_REQ_GUARD_STAT_EN
  logic [31:0] txn_cnt_d;
  logic [15:0] tmo_cnt_d;

  assign txn_cnt_d = txn_cnt_o + {31'h0, (state_q == RESP)};
  assign tmo_cnt_d = (tmo_set && (tmo_cnt_o != 16'hFFFF)) ? tmo_cnt_o + 16'h1 : tmo_cnt_o;

  dffr #(.W(32)) u_txn_cnt (.clk_i(clk_i), .rst_n_i(rst_n_i), .d(txn_cnt_d), .q(txn_cnt_o));
  dffr #(.W(16)) u_tmo_cnt (.clk_i(clk_i), .rst_n_i(rst_n_i), .d(tmo_cnt_d), .q(tmo_cnt_o));
`else
  assign txn_cnt_o = 32'h0;
  assign tmo_cnt_o = 16'h0;
`endif

endmodule
